// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx : PS/2 keyboard receiver for the CPU keyboard input path.
//
// Conditions the raw PS/2 clock and data lines, deframes 11-bit frames
// (start, 8 data LSB first, parity, stop) and queues good bytes in a small
// FIFO. The CPU reads a registered status/data word and pops the head byte
// with a single-cycle strobe.
//
// Ports:
//   clock     50 MHz system clock
//   rst       asynchronous active-high reset
//   ps2_clk   raw PS/2 clock from the device (asynchronous)
//   ps2_data  raw PS/2 data from the device (asynchronous)
//   pop       single-cycle strobe, discard the FIFO head
//   clr_err   single-cycle strobe, clear the overrun and frame_err flags
//   rd_data   {17'b0, count[3:0], frame_err, overrun, valid, head[7:0]}
//   valid     FIFO not empty
//
// Build option:
//   PS2_PARITY_EN  when defined, odd parity is checked and a parity failure
//                  discards the frame and sets frame_err. When undefined the
//                  parity bit is consumed and ignored.

module ps2_kbd_rx #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int FILTER_LEN     = 4
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        pop,
   input  logic        clr_err,
   output logic [31:0] rd_data,
   output logic        valid
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
   localparam int FL_W  = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frameState_t;

   logic [1:0]       clkSync;
   logic [1:0]       dataSync;
   logic             filtClk;
   logic             filtPrev;
   logic [FL_W-1:0]  filtCnt;
   logic             bitEvent;
   logic             bitData;

   frameState_t      state;
   frameState_t      stateNext;
   logic [2:0]       bitIdx;
   logic [7:0]       shiftReg;
   logic [TO_W-1:0]  timeoutCnt;
   logic             timedOut;
   logic             parityOk;
   logic             stopEvent;
   logic             pushPending;
   logic             errPending;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] rdPtrNext;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] countNext;
   logic             doPush;
   logic             doPop;
   logic             overrun;
   logic             frameErr;
   logic             overrunNext;
   logic             frameErrNext;
   logic [7:0]       headNext;
   logic [3:0]       countWide;

`ifdef PS2_PARITY_EN
   logic             parityBit;
`endif

   // Two-flop synchronizers for both lines. They reset to the idle-high
   // level so that reset release never looks like a falling clock edge.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         clkSync  <= 2'b11;
         dataSync <= 2'b11;
      end else begin
         clkSync  <= {clkSync[0], ps2_clk};
         dataSync <= {dataSync[0], ps2_data};
      end
   end

   // Glitch filter on the synchronized clock: the filtered level only flips
   // once FILTER_LEN consecutive samples disagree with it; any agreeing
   // sample restarts the run. filtPrev keeps last cycle's level for edge
   // detection.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         filtClk  <= 1'b1;
         filtPrev <= 1'b1;
         filtCnt  <= '0;
      end else begin
         filtPrev <= filtClk;
         if (clkSync[1] != filtClk) begin
            if (filtCnt == FL_W'(FILTER_LEN - 1)) begin
               filtClk <= clkSync[1];
               filtCnt <= '0;
            end else begin
               filtCnt <= filtCnt + 1'b1;
            end
         end else begin
            filtCnt <= '0;
         end
      end
   end

   assign bitEvent = filtPrev & ~filtClk;
   assign bitData  = dataSync[1];
   assign timedOut = (state != IDLE) && (timeoutCnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_EN
   assign parityOk = ^{shiftReg, parityBit};
`else
   assign parityOk = 1'b1;
`endif

   assign stopEvent = bitEvent && (state == STOP);

   // Frame next-state logic. A bit event takes priority over the timeout,
   // since the event also restarts the idle counter.
   always_comb begin
      stateNext = state;
      if (bitEvent) begin
         case (state)
            IDLE:    if (!bitData) stateNext = DATA;
            DATA:    if (bitIdx == 3'd7) stateNext = PARITY;
            PARITY:  stateNext = STOP;
            STOP:    stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end else if (timedOut) begin
         stateNext = IDLE;
      end
   end

   // Frame state register and deframing datapath. The byte stays in shiftReg
   // through the push cycle because no new shifting can begin until a fresh
   // start bit arrives many clocks later.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bitIdx      <= '0;
         shiftReg    <= '0;
         timeoutCnt  <= '0;
         pushPending <= 1'b0;
         errPending  <= 1'b0;
`ifdef PS2_PARITY_EN
         parityBit   <= 1'b0;
`endif
      end else begin
         state       <= stateNext;
         pushPending <= stopEvent && bitData && parityOk;
         errPending  <= stopEvent && !(bitData && parityOk);
         if (bitEvent || state == IDLE || timedOut) begin
            timeoutCnt <= '0;
         end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
         end
         if (bitEvent) begin
            case (state)
               IDLE: bitIdx <= '0;
               DATA: begin
                  shiftReg <= {bitData, shiftReg[7:1]};
                  bitIdx   <= bitIdx + 1'b1;
               end
`ifdef PS2_PARITY_EN
               PARITY: parityBit <= bitData;
`endif
               default: ;
            endcase
         end
      end
   end

   // FIFO bookkeeping. A pop on a full FIFO frees the slot the same cycle, so
   // a coincident push is accepted. The head and flags are computed from the
   // post-update state so rd_data and valid change together.
   always_comb begin
      doPop        = pop && (count != '0);
      doPush       = pushPending && ((count != CNT_W'(FIFO_DEPTH)) || doPop);
      countNext    = count + CNT_W'(doPush) - CNT_W'(doPop);
      rdPtrNext    = doPop ? rdPtr + 1'b1 : rdPtr;
      overrunNext  = (pushPending && !doPush) || (overrun && !clr_err);
      frameErrNext = errPending || (frameErr && !clr_err);
      countWide    = 4'(countNext);
      headNext     = mem[rdPtrNext];
      if (countNext == '0) begin
         headNext = 8'h00;
      end else if (doPush && ((count == '0) || (count == CNT_W'(1) && doPop))) begin
         headNext = shiftReg;
      end
   end

   // FIFO storage has no reset; entries are only read once written.
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem[wrPtr] <= shiftReg;
      end
   end

   // FIFO pointers, sticky flags and the registered CPU read word.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overrun  <= 1'b0;
         frameErr <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         rdPtr    <= rdPtrNext;
         count    <= countNext;
         overrun  <= overrunNext;
         frameErr <= frameErrNext;
         rd_data  <= {17'b0, countWide, frameErrNext, overrunNext,
                      (countNext != '0), headNext};
      end
   end

   assign valid = rd_data[8];

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx : scoreboard bench for ps2_kbd_rx. Frames are driven on the
// PS/2 lines with a shortened bit period; every byte expected to reach the
// FIFO is queued, and a monitor compares the head each time a pop strobe
// meets a non-empty FIFO. Status words are checked with hand-computed values.

module tb_ps2_kbd_rx;

   localparam int TIMEOUT = 200;
   localparam int HALF    = 20;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        ps2Clk = 1'b1;
   logic        ps2Data = 1'b1;
   logic        pop = 1'b0;
   logic        clrErr = 1'b0;
   logic [31:0] rdData;
   logic        valid;

   logic [7:0]  expQ [$];
   int          checkCount = 0;
   int          passCount = 0;

   ps2_kbd_rx #(
      .FIFO_DEPTH(8),
      .TIMEOUT_CYCLES(TIMEOUT),
      .FILTER_LEN(4)
   ) dut (
      .clock(clock),
      .rst(rst),
      .ps2_clk(ps2Clk),
      .ps2_data(ps2Data),
      .pop(pop),
      .clr_err(clrErr),
      .rd_data(rdData),
      .valid(valid)
   );

   // 50 MHz system clock.
   always #10 clock = ~clock;

   // Hang guard.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic oddPar(input logic [7:0] b);
      return ~^b;
   endfunction

   // Monitor: when a pop strobe meets a non-empty FIFO, the head on rd_data
   // must be the oldest byte still expected.
   always @(negedge clock) begin
      if (!rst && pop) begin
         if (valid) begin
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL popHead: got %h, required no data queued", rdData[7:0]);
            end else begin
               logic [7:0] expByte;
               expByte = expQ.pop_front();
               if (rdData[7:0] === expByte) passCount++;
               else $display("[TB] FAIL popHead: got %h, required %h", rdData[7:0], expByte);
            end
         end else if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL popEmpty: valid low, required head %h", expQ[0]);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] expWord);
      checkCount++;
      if (rdData === expWord) passCount++;
      else $display("[TB] FAIL %s rd_data: got %h, required %h", name, rdData, expWord);
      checkCount++;
      if (valid === expWord[8]) passCount++;
      else $display("[TB] FAIL %s valid: got %b, required %b", name, valid, expWord[8]);
   endtask

   // Sends the first nBits bits of a frame. glitch injects a 2-cycle low
   // pulse during the high phase of bit 3. popAtPush pulses pop on the
   // cycle the FIFO push happens: the stop bit event lags the raw falling
   // edge by the synchronizer plus filter, and the push follows one cycle on.
   task automatic applyStimulus(input logic [7:0] b, input logic parity, input logic stopBit,
                                input int nBits, input bit glitch, input bit popAtPush);
      logic [10:0] frame;
      frame = {stopBit, parity, b, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         @(negedge clock);
         ps2Data = frame[i];
         if (glitch && i == 3) begin
            repeat (5) @(negedge clock);
            ps2Clk = 1'b0;
            repeat (2) @(negedge clock);
            ps2Clk = 1'b1;
            repeat (HALF - 7) @(negedge clock);
         end else begin
            repeat (HALF) @(negedge clock);
         end
         ps2Clk = 1'b0;
         if (popAtPush && i == 10) begin
            repeat (7) @(posedge clock);
            #2 pop = 1'b1;
            @(posedge clock);
            #2 pop = 1'b0;
            repeat (HALF - 8) @(negedge clock);
         end else begin
            repeat (HALF) @(negedge clock);
         end
         ps2Clk = 1'b1;
      end
      repeat (HALF) @(negedge clock);
      ps2Data = 1'b1;
      repeat (10) @(negedge clock);
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(b, oddPar(b), 1'b1, 11, 1'b0, 1'b0);
      expQ.push_back(b);
   endtask

   task automatic pulsePop();
      @(posedge clock);
      #2 pop = 1'b1;
      @(posedge clock);
      #2 pop = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic pulseClr();
      @(posedge clock);
      #2 clrErr = 1'b1;
      @(posedge clock);
      #2 clrErr = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clock);
      checkOutput("inReset", 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("afterReset", 32'h0);

      // Single byte, then pop.
      sendByte(8'h1C);
      checkOutput("single", 32'h0000_091C);
      pulsePop();
      checkOutput("singlePopped", 32'h0);

      // Three back-to-back bytes, three pops, extra pop on empty.
      sendByte(8'h1C);
      sendByte(8'hF0);
      sendByte(8'h1C);
      checkOutput("three", 32'h0000_191C);
      repeat (3) pulsePop();
      pulsePop();
      checkOutput("emptyPop", 32'h0);

      // Nine bytes with no pops: eighth fills the FIFO, ninth overruns.
      for (int i = 1; i <= 9; i++) begin
         logic [7:0] b;
         b = 8'(i);
         applyStimulus(b, oddPar(b), 1'b1, 11, 1'b0, 1'b0);
         if (i <= 8) expQ.push_back(b);
      end
      checkOutput("full", 32'h0000_4301);
      applyStimulus(8'h0A, oddPar(8'h0A), 1'b1, 11, 1'b0, 1'b1);
      expQ.push_back(8'h0A);
      checkOutput("fullPushPop", 32'h0000_4302);
      pulseClr();
      checkOutput("overrunCleared", 32'h0000_4102);
      repeat (8) pulsePop();
      checkOutput("drained", 32'h0);

      // Bad stop bit, then a good frame.
      applyStimulus(8'h33, oddPar(8'h33), 1'b0, 11, 1'b0, 1'b0);
      checkOutput("frameErr", 32'h0000_0400);
      sendByte(8'h2A);
      checkOutput("afterFrameErr", 32'h0000_0D2A);
      pulsePop();
      pulseClr();
      checkOutput("frameErrCleared", 32'h0);

      // Partial frame abandoned by the timeout, then a full frame.
      applyStimulus(8'h0F, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      repeat (TIMEOUT + 20) @(negedge clock);
      sendByte(8'h55);
      checkOutput("afterTimeout", 32'h0000_0955);
      pulsePop();

      // Short low glitches on ps2_clk must be filtered out.
      applyStimulus(8'hA5, oddPar(8'hA5), 1'b1, 11, 1'b1, 1'b0);
      expQ.push_back(8'hA5);
      checkOutput("glitch", 32'h0000_09A5);
      pulsePop();

      // Wrong parity bit for 0x1C.
      applyStimulus(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
`ifdef PS2_PARITY_EN
      checkOutput("badParity", 32'h0000_0400);
      pulseClr();
`else
      expQ.push_back(8'h1C);
      checkOutput("parityIgnored", 32'h0000_091C);
      pulsePop();
`endif
      checkOutput("final", 32'h0);

      checkCount++;
      if (expQ.size() == 0) passCount++;
      else $display("[TB] FAIL leftover: got %0d bytes unpopped, required 0", expQ.size());

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
